// File: rtl/mux4_scan_ctrl.sv
// Select sequencer for a 4:1 mux: walks enabled channels, samples F after DWELL cycles each,
// publishes an atomic 4-bit snapshot with a done pulse. Define CONTINUOUS_EN to rescan from DONE.
module mux4_scan_ctrl #(
   parameter int DWELL = 2,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] mask,
   input  logic       F,
   output logic [1:0] Sel,
   output logic       busy,
   output logic       done,
   output logic [3:0] snapshot
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       mask_q, mask_d;
   logic [3:0]       shadow_q, shadow_d;
   logic [3:0]       snap_q, snap_d;
   logic             nextValid;
   logic [1:0]       nextSel;

   function automatic logic [1:0] lowestChan(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   // Closest enabled channel above the one currently selected, if any.
   always_comb begin
      nextValid = 1'b0;
      nextSel   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(sel_q))) begin
            nextValid = 1'b1;
            nextSel   = 2'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      snap_d   = snap_q;
      case (state_q)
         IDLE: begin
            sel_d = 2'd0;
            cnt_d = '0;
            if (start) begin
               mask_d   = mask;
               shadow_d = 4'd0;
               if (mask != 4'd0) begin
                  state_d = SCAN;
                  sel_d   = lowestChan(mask);
               end else begin
                  state_d = DONE;
                  snap_d  = 4'd0;
               end
            end
         end
         SCAN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DWELL - 1)) begin
               shadow_d[sel_q] = F;
               cnt_d           = '0;
               if (nextValid) begin
                  sel_d = nextSel;
               end else begin
                  // Publish including the sample taken on this same edge.
                  state_d = DONE;
                  sel_d   = 2'd0;
                  snap_d  = shadow_d;
               end
            end
         end
         DONE: begin
            sel_d = 2'd0;
            cnt_d = '0;
`ifdef CONTINUOUS_EN
            mask_d = mask;
            if (mask != 4'd0) begin
               state_d  = SCAN;
               sel_d    = lowestChan(mask);
               shadow_d = 4'd0;
            end else begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
            sel_d   = 2'd0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= 2'd0;
         cnt_q    <= '0;
         mask_q   <= 4'd0;
         shadow_q <= 4'd0;
         snap_q   <= 4'd0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         snap_q   <= snap_d;
      end
   end

   assign Sel      = sel_q;
   assign busy     = (state_q == SCAN);
   assign done     = (state_q == DONE);
   assign snapshot = snap_q;

endmodule
